adc_2308_emulator: RTL and testbench
====================================

// Module: adc_2308_emulator
// PURPOSE
//  SPI responder emulating the LTC2308 8-ch 12-bit ADC. It is the far end of the embedded_adc master
//  (adc_cs_n/adc_sclk/adc_din in, adc_dout out).
//  Serves samples from a parallel bus (data_source or a testbench) so the ADC-2308 path runs on-board or in sim.
//  Oversampled design: clk must be >= 4x adc_sclk.
// PARAMETERS
//  CONV_CYCLES   64   clk cycles of conversion after adc_cs_n rising edge (busy window)
//  N_BITS        12   result width (fixed 12; other values unsupported)
// PORTS
//  clk             in   1      single clock; all logic on posedge
//  reset           in   1      asynchronous, active-high reset
//  sample_data_in  in   96     8 x 12-bit channel samples; ch k at [12k+11:12k]; straight binary
//  adc_cs_n        in   1      CONVST from master; rising edge starts conversion, low = data phase
//  adc_sclk        in   1      serial clock from master
//  adc_din         in   1      config bits from master, MSB first: S/D O/S S1 S0 UNI SLP
//  adc_dout        out  1      result, MSB first
//  cfg_word        out  6      config in force for the next conversion
//  cfg_valid       out  1      1-clk pulse when a full frame updates cfg_word
//  conv_busy       out  1      high during CONVERT
//  frame_count     out  16     completed 12-bit frames; wraps 0xFFFF->0
//  err_short_frame out  1      1-clk pulse: adc_cs_n rose before 12 sclk falling edges
// BEHAVIOUR
//  - Inputs pass a 2-FF synchronizer; edges detected on synced signals (2-3 clk latency to any reaction).
//  - Reset values: adc_dout=0, cfg_word=6'b100010 (SE, ch0, unipolar), cfg_valid=0, conv_busy=0,
//    frame_count=0, err_short_frame=0, FSM=IDLE, shift regs=0.
//  - FSM IDLE -> CONVERT on cs rising.
//    CONVERT: latch result from cfg_word; count CONV_CYCLES; cs edges and sclk ignored.
//    CONVERT -> READY when count done.
//    READY -> SHIFT on cs low (immediately if already low); dout = result[11].
//    SHIFT: sclk rising samples din into cfg shift reg; sclk falling shifts next bit onto dout.
//  - SHIFT after the 12th falling edge: dout=0; cfg_word<=captured 6 bits (first 6 rising edges);
//    cfg_valid pulse; frame_count+1; -> DONE.
//    Further sclk edges in DONE are ignored. cs rising in DONE -> CONVERT.
//  - cs rising in SHIFT with <12 falling edges:
//    err_short_frame pulse, cfg_word unchanged, frame_count unchanged; -> CONVERT.
//  - Channel select {O/S,S1,S0}: 000 ch0, 100 ch1, 001 ch2, 101 ch3, 010 ch4, 110 ch5, 011 ch6, 111 ch7.
//    S/D=0 (differential) uses the same mapping, no subtraction.
//    SLP is captured but ignored.
//  - UNI=1: result=sample. UNI=0: result=sample ^ 12'h800 (offset-binary to two's complement).
//  - Result is the conversion started by this frame's leading cs edge, using config from the previous frame
//    (one-frame config latency, as the real device).
//  - Reset asserted mid-frame aborts immediately; outputs take reset values.
// CONFIGURATION
//  ADC_EMU_NOISE_EN defined:
//    16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) steps once per conversion.
//    lfsr[1:0] is added to the 12-bit result before UNI formatting, saturating at 12'hFFF.
//  Undefined: result is the exact sample; no LFSR logic present.
// STRUCTURE
//  - adc_emu_pkg: FSM state enum (IDLE,CONVERT,READY,SHIFT,DONE), RESET_CFG=6'b100010,
//    channel-map function, LFSR seed/taps.
//  - Sub-module sync_edge_det: 2-FF sync + rise/fall pulses; instantiated for cs, sclk, din
//    (edges unused on din).
// TESTING  (clk 40 MHz, sclk 2.5 MHz unless noted)
//  1. After reset, cs pulse, 12 clocks with din=6'b100010:
//     dout shifts ch0 sample 12'hA5C MSB first; cfg_valid pulse; frame_count=1.
//  2. Frame A with din=6'b110010, then frame B:
//     B returns ch1 (12'h3F1); A still returned ch0 (one-frame latency).
//  3. UNI=0 config, ch0=12'h000 -> next frame dout reads 12'h800; ch0=12'hFFF -> 12'h7FF.
//  4. cs rises after 5 sclk:
//     err_short_frame pulse, cfg_word unchanged, frame_count unchanged, new CONVERT begins.
//  5. sclk toggled during CONVERT and 16 sclk in a frame:
//     no shifts in CONVERT, dout=0 after bit 12, frame_count +1 only.
//  6. Reset mid-SHIFT (bit 6): all outputs return to reset values within the same cycle;
//     next full frame is correct.
//     Build with ADC_EMU_NOISE_EN: ch0=12'hFFF stays 12'hFFF (saturation); ch0=12'h100 reads 12'h100..12'h103.

Source files
------------

// File: rtl/adc_emu_pkg.sv
// Shared types and helpers for the LTC2308 SPI responder.
// Holds the FSM states, reset config, channel decode and the noise LFSR constants.
package adc_emu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    READY,
    SHIFT,
    DONE
  } emu_state_t;

  localparam int          CFG_BITS  = 6;
  localparam logic [5:0]  RESET_CFG = 6'b100010;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // sel = {O/S, S1, S0}; the part's channel index is {S1, S0, O/S}
  function automatic logic [2:0] cfg_to_channel(input logic [2:0] sel);
    return {sel[1], sel[0], sel[2]};
  endfunction

  function automatic logic [11:0] format_result(input logic [11:0] raw, input logic uni);
    return uni ? raw : (raw ^ 12'h800);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with single-cycle rise/fall pulses on the synchronized level.
module sync_edge_det #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
      prev_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign q    = sync_reg;
  assign rise = sync_reg & ~prev_reg;
  assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/adc_2308_emulator.sv
// LTC2308 SPI responder serving samples from a parallel bus; clk must be >= 4x adc_sclk.
// Optional build macro ADC_EMU_NOISE_EN adds 0..3 LSB of LFSR noise with saturation.
module adc_2308_emulator
  import adc_emu_pkg::*;
#(
  parameter int CONV_CYCLES = 64,
  parameter int N_BITS      = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*N_BITS-1:0]   sample_data_in,
  input  logic                  adc_cs_n,
  input  logic                  adc_sclk,
  input  logic                  adc_din,
  output logic                  adc_dout,
  output logic [5:0]            cfg_word,
  output logic                  cfg_valid,
  output logic                  conv_busy,
  output logic [15:0]           frame_count,
  output logic                  err_short_frame
);

  localparam int CNT_W = $clog2(CONV_CYCLES + 1);
  localparam int BIT_W = $clog2(N_BITS + 1);

  logic cs_sync, cs_rise, cs_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic din_sync, din_rise, din_fall;
  logic edges_unused;

  // cs idles high, so its synchronizer resets high to avoid a false start after reset
  sync_edge_det #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .d(adc_cs_n), .q(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );
  sync_edge_det #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .d(adc_sclk), .q(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge_det #(.RESET_VAL(1'b0)) u_din_sync (
    .clk(clk), .reset(reset), .d(adc_din), .q(din_sync), .rise(din_rise), .fall(din_fall)
  );

  assign edges_unused = ^{cs_fall, sclk_sync, din_rise, din_fall};

  logic [N_BITS-1:0] samples [8];
  for (genvar gi = 0; gi < 8; gi++) begin : g_ch
    assign samples[gi] = sample_data_in[N_BITS*gi +: N_BITS];
  end

  emu_state_t        state_reg;
  logic [CNT_W-1:0]  conv_cnt_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [2:0]        rise_cnt_reg;
  logic [5:0]        cfg_shift_reg;
  logic [N_BITS-1:0] result_reg;
  logic [N_BITS-1:0] shift_reg;
  logic [N_BITS-1:0] raw_sample;
  logic [N_BITS-1:0] adj_sample;
  logic [N_BITS-1:0] conv_result;
  logic              start_conv;

  assign raw_sample = samples[cfg_to_channel(cfg_word[4:2])];
  assign start_conv = cs_rise &&
                      (state_reg == IDLE || state_reg == SHIFT || state_reg == DONE);

`ifdef ADC_EMU_NOISE_EN
  logic [15:0]     lfsr_reg;
  logic [N_BITS:0] noisy_sum;

  assign noisy_sum  = {1'b0, raw_sample} + {{(N_BITS-1){1'b0}}, lfsr_reg[1:0]};
  assign adj_sample = noisy_sum[N_BITS] ? {N_BITS{1'b1}} : noisy_sum[N_BITS-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_reg <= LFSR_SEED;
    end else if (start_conv) begin
      lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
    end
  end
`else
  assign adj_sample = raw_sample;
`endif

  assign conv_result = format_result(adj_sample, cfg_word[1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      conv_cnt_reg    <= '0;
      bit_cnt_reg     <= '0;
      rise_cnt_reg    <= '0;
      cfg_shift_reg   <= '0;
      result_reg      <= '0;
      shift_reg       <= '0;
      adc_dout        <= 1'b0;
      cfg_word        <= RESET_CFG;
      cfg_valid       <= 1'b0;
      conv_busy       <= 1'b0;
      frame_count     <= '0;
      err_short_frame <= 1'b0;
    end else begin
      cfg_valid       <= 1'b0;
      err_short_frame <= 1'b0;
      // A cs rise from any non-converting state restarts; in SHIFT it means the frame was cut short
      if (start_conv) begin
        state_reg       <= CONVERT;
        conv_cnt_reg    <= '0;
        result_reg      <= conv_result;
        conv_busy       <= 1'b1;
        adc_dout        <= 1'b0;
        err_short_frame <= (state_reg == SHIFT);
      end else begin
        case (state_reg)
          CONVERT: begin
            if (conv_cnt_reg == CNT_W'(CONV_CYCLES - 1)) begin
              state_reg <= READY;
              conv_busy <= 1'b0;
            end else begin
              conv_cnt_reg <= conv_cnt_reg + 1'b1;
            end
          end
          READY: begin
            if (!cs_sync) begin
              state_reg     <= SHIFT;
              adc_dout      <= result_reg[N_BITS-1];
              shift_reg     <= {result_reg[N_BITS-2:0], 1'b0};
              bit_cnt_reg   <= '0;
              rise_cnt_reg  <= '0;
              cfg_shift_reg <= '0;
            end
          end
          SHIFT: begin
            if (sclk_rise) begin
              if (rise_cnt_reg != 3'(CFG_BITS)) begin
                cfg_shift_reg <= {cfg_shift_reg[4:0], din_sync};
                rise_cnt_reg  <= rise_cnt_reg + 1'b1;
              end
            end else if (sclk_fall) begin
              if (bit_cnt_reg == BIT_W'(N_BITS - 1)) begin
                state_reg   <= DONE;
                adc_dout    <= 1'b0;
                cfg_word    <= cfg_shift_reg;
                cfg_valid   <= 1'b1;
                frame_count <= frame_count + 16'd1;
              end else begin
                adc_dout    <= shift_reg[N_BITS-1];
                shift_reg   <= {shift_reg[N_BITS-2:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_2308_emulator.sv
// Scoreboard bench for adc_2308_emulator: acts as the SPI master, predicts each frame's result.
`timescale 1ns/100ps
module tb_adc_2308_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [95:0] sample_data_in;
  logic        adc_cs_n, adc_sclk, adc_din;
  logic        adc_dout;
  logic [5:0]  cfg_word;
  logic        cfg_valid, conv_busy, err_short_frame;
  logic [15:0] frame_count;

  adc_2308_emulator dut (
    .clk(clk), .reset(reset), .sample_data_in(sample_data_in),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din),
    .adc_dout(adc_dout), .cfg_word(cfg_word), .cfg_valid(cfg_valid),
    .conv_busy(conv_busy), .frame_count(frame_count), .err_short_frame(err_short_frame)
  );

  always #12.5 clk = ~clk;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  logic [11:0] exp_q[$];
  logic [5:0]  model_cfg;
  int          model_frames;
  int          exp_err;
  int          valid_pulses;
  int          err_pulses;
  logic [15:0] model_lfsr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      valid_pulses = 0;
      err_pulses   = 0;
    end else begin
      if (cfg_valid) valid_pulses++;
      if (err_short_frame) err_pulses++;
    end
  end

  function automatic int ch_of(input logic [5:0] cfg);
    case ({cfg[4], cfg[3], cfg[2]})
      3'b000: return 0;
      3'b100: return 1;
      3'b001: return 2;
      3'b101: return 3;
      3'b010: return 4;
      3'b110: return 5;
      3'b011: return 6;
      default: return 7;
    endcase
  endfunction

  // Single-ended, unipolar config that selects channel k
  function automatic logic [5:0] cfg_for_ch(input int k);
    logic [2:0] kb;
    kb = 3'(k);
    return {1'b1, kb[0], kb[2], kb[1], 1'b1, 1'b0};
  endfunction

  function automatic logic [11:0] model_result();
    logic [11:0] raw;
    raw = sample_data_in[ch_of(model_cfg)*12 +: 12];
`ifdef ADC_EMU_NOISE_EN
    begin
      logic [12:0] sum;
      sum = {1'b0, raw} + {11'd0, model_lfsr[1:0]};
      raw = sum[12] ? 12'hFFF : sum[11:0];
    end
`endif
    return model_cfg[1] ? raw : (raw ^ 12'h800);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input int ch, input logic [11:0] v);
    sample_data_in[ch*12 +: 12] = v;
  endtask

  task automatic cs_rise_edge();
    exp_q.push_back(model_result());
    model_lfsr = {model_lfsr[14:0], model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
    adc_cs_n = 1'b1;
    wait_clk(5);
    check("conv_busy_on", conv_busy, 1);
  endtask

  task automatic cs_pulse();
    adc_cs_n = 1'b0;
    wait_clk(4);
    cs_rise_edge();
  endtask

  task automatic enter_data();
    adc_cs_n = 1'b0;
    wait_clk(80);
  endtask

  task automatic shift_bits(input logic [5:0] cfg, input int n, output logic [11:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      adc_din = (i < 6) ? cfg[5-i] : 1'b0;
      wait_clk(8);
      @(negedge clk);
      if (i < 12) got = {got[10:0], adc_dout};
      wait_clk(1);
      adc_sclk = 1'b1;
      wait_clk(8);
      adc_sclk = 1'b0;
    end
    adc_din = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input logic [5:0] cfg, input int n);
    logic [11:0] got;
    logic [11:0] exp;
    shift_bits(cfg, n, got);
    wait_clk(8);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_data"}, got, exp);
    end
    model_cfg = cfg;
    model_frames++;
    check({tag, "_dout_after"}, adc_dout, 0);
    check({tag, "_frame_count"}, frame_count, model_frames);
    check({tag, "_cfg_valid_pulses"}, valid_pulses, model_frames);
    check({tag, "_cfg_word"}, cfg_word, model_cfg);
    check({tag, "_busy_off"}, conv_busy, 0);
  endtask

  task automatic full_frame(input string tag, input logic [5:0] cfg, input int n);
    cs_pulse();
    enter_data();
    finish_frame(tag, cfg, n);
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_cfg    = 6'b100010;
    model_frames = 0;
    exp_err      = 0;
    model_lfsr   = 16'hACE1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] tmp;
    reset = 1'b1; adc_cs_n = 1'b1; adc_sclk = 1'b0; adc_din = 1'b0;
    sample_data_in = '0;
    set_sample(0, 12'hA5C); set_sample(1, 12'h3F1); set_sample(2, 12'h123);
    set_sample(3, 12'h456); set_sample(4, 12'h789); set_sample(5, 12'hABC);
    set_sample(6, 12'hDEF); set_sample(7, 12'h0F0);
    model_reset();
    wait_clk(4);
    reset = 1'b0;
    wait_clk(4);
    @(negedge clk);
    check("rst_dout", adc_dout, 0);
    check("rst_cfg_word", cfg_word, 6'b100010);
    check("rst_cfg_valid", cfg_valid, 0);
    check("rst_conv_busy", conv_busy, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_err_short", err_short_frame, 0);

    full_frame("t1_ch0", 6'b100010, 12);
    full_frame("t2_frameA", 6'b110010, 12);
    full_frame("t2_frameB", 6'b100010, 12);

    full_frame("t3_set_bipolar", 6'b100000, 12);
    set_sample(0, 12'h000);
    full_frame("t3_zero", 6'b100000, 12);
    set_sample(0, 12'hFFF);
    full_frame("t3_full", 6'b100010, 12);
    set_sample(0, 12'hA5C);

    for (int k = 0; k < 8; k++) full_frame($sformatf("sweep_ch%0d", k), cfg_for_ch(k), 12);
    full_frame("sweep_tail", 6'b100010, 12);

    // Short frame: cs rises after 5 clocks
    cs_pulse();
    enter_data();
    shift_bits(6'b111111, 5, tmp);
    void'(exp_q.pop_front());
    cs_rise_edge();
    exp_err++;
    check("t4_err_pulse", err_pulses, exp_err);
    check("t4_cfg_word", cfg_word, model_cfg);
    check("t4_frame_count", frame_count, model_frames);
    enter_data();
    finish_frame("t4_after_short", 6'b101010, 12);
    check("t4_no_extra_err", err_pulses, exp_err);

    // sclk activity during CONVERT, then 16 clocks in the data phase
    cs_pulse();
    adc_cs_n = 1'b0;
    repeat (3) begin
      wait_clk(8); adc_sclk = 1'b1;
      wait_clk(8); adc_sclk = 1'b0;
    end
    wait_clk(40);
    finish_frame("t5_long", 6'b100010, 16);

    // Reset in the middle of the data phase
    cs_pulse();
    enter_data();
    shift_bits(6'b110110, 6, tmp);
    wait_clk(3);
    reset = 1'b1;
    #1;
    check("t6_dout", adc_dout, 0);
    check("t6_cfg_word", cfg_word, 6'b100010);
    check("t6_cfg_valid", cfg_valid, 0);
    check("t6_conv_busy", conv_busy, 0);
    check("t6_frame_count", frame_count, 0);
    check("t6_err_short", err_short_frame, 0);
    model_reset();
    adc_sclk = 1'b0; adc_din = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    full_frame("t6_post_reset", 6'b100010, 12);

`ifdef ADC_EMU_NOISE_EN
    set_sample(0, 12'hFFF);
    full_frame("noise_sat", 6'b100010, 12);
    set_sample(0, 12'h100);
    for (int k = 0; k < 4; k++) full_frame($sformatf("noise_%0d", k), 6'b100010, 12);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
